// File: rtl/rotate_aligner_if.sv
// Byte-stream bus between the rotating link and the aligner.
//   din/din_valid     : rotated input word and its qualifier (master -> slave)
//   dout/dout_valid   : de-rotated payload word and its one-cycle strobe
//   amt               : recovered rotation amount
//   locked            : alignment established
// The aligner is the slave; the upstream source / testbench is the master.
interface rotate_aligner_if;
    logic [7:0] din;
    logic       din_valid;
    logic [7:0] dout;
    logic       dout_valid;
    logic [2:0] amt;
    logic       locked;

    modport master (
        output din, din_valid,
        input  dout, dout_valid, amt, locked
    );

    modport slave (
        input  din, din_valid,
        output dout, dout_valid, amt, locked
    );
endinterface

// File: rtl/rotate_aligner.sv
// rotate_aligner: recovers the unknown left-rotation applied to a framed byte
// stream by hunting for the sync word, confirms it over several frames, then
// locks and streams de-rotated payload.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : rotate_aligner_if.slave (din, din_valid in; dout, dout_valid,
//            amt, locked out; all outputs registered)
//
// state   | meaning
// --------+---------------------------------------------------------------
// HUNT    | searching every rotation of each word for the sync pattern
// CONFIRM | candidate rotation found; counting consecutive sync-slot hits
// LOCKED  | alignment established; payload de-rotated and output
module rotate_aligner #(
    parameter logic [7:0] SYNC      = 8'hB0,
    parameter int         FRAME_LEN = 4,
    parameter int         LOCK_CNT  = 3,
    parameter int         LOSS_CNT  = 4
) (
    input  logic             clk,
    input  logic             reset,
    rotate_aligner_if.slave  bus
);

    localparam logic [3:0] POS_LAST = 4'(FRAME_LEN - 1);
    localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_C   = 4'(LOSS_CNT);

    typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

    state_t     state, state_nxt;
    logic [3:0] pos, pos_nxt;
    logic [3:0] hit_cnt, hit_nxt;
    logic [3:0] miss_cnt, miss_nxt;
    logic [7:0] dout_r, dout_nxt;
    logic       dv_r, dv_nxt;
    logic [2:0] amt_r, amt_nxt;
    logic       locked_r, locked_nxt;

    logic       hunt_match;
    logic [2:0] hunt_k;
    logic [7:0] derot;
    logic       sync_hit;
    logic [3:0] pos_adv;

    function automatic logic [7:0] rotr(input logic [7:0] x, input logic [2:0] k);
        logic [15:0] d;
        d = {x, x} >> k;
        return d[7:0];
    endfunction

    // All eight rotations of SYNC are distinct, so at most one k can match.
    always_comb begin
        hunt_match = 1'b0;
        hunt_k     = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (!hunt_match && rotr(bus.din, 3'(k)) == SYNC) begin
                hunt_match = 1'b1;
                hunt_k     = 3'(k);
            end
        end
    end

    assign derot    = rotr(bus.din, amt_r);
    assign sync_hit = (derot == SYNC);
    assign pos_adv  = (pos == POS_LAST) ? 4'd0 : pos + 4'd1;

    always_comb begin
        state_nxt  = state;
        pos_nxt    = pos;
        hit_nxt    = hit_cnt;
        miss_nxt   = miss_cnt;
        dout_nxt   = dout_r;
        dv_nxt     = 1'b0;
        amt_nxt    = amt_r;
        locked_nxt = locked_r;

        if (bus.din_valid) begin
            case (state)
                HUNT: begin
                    if (hunt_match) begin
                        amt_nxt = hunt_k;
                        hit_nxt = 4'd1;
                        pos_nxt = 4'd1;
                        if (LOCK_CNT == 1) begin
                            state_nxt  = LOCKED;
                            locked_nxt = 1'b1;
                            miss_nxt   = 4'd0;
                        end else begin
                            state_nxt = CONFIRM;
                        end
                    end
                end

                CONFIRM: begin
                    pos_nxt = pos_adv;
                    if (pos == 4'd0) begin
                        if (sync_hit) begin
                            hit_nxt = hit_cnt + 4'd1;
                            if (hit_nxt == LOCK_C) begin
                                state_nxt  = LOCKED;
                                locked_nxt = 1'b1;
                                miss_nxt   = 4'd0;
                            end
                        end else begin
                            // The missed word is deliberately not re-hunted.
                            state_nxt = HUNT;
                            hit_nxt   = 4'd0;
                            pos_nxt   = 4'd0;
                        end
                    end
                end

                LOCKED: begin
                    pos_nxt = pos_adv;
                    if (pos != 4'd0) begin
                        dout_nxt = derot;
                        dv_nxt   = 1'b1;
                    end else if (sync_hit) begin
                        miss_nxt = 4'd0;
                    end else begin
                        miss_nxt = miss_cnt + 4'd1;
                        if (miss_nxt == LOSS_C) begin
                            state_nxt  = HUNT;
                            locked_nxt = 1'b0;
                            miss_nxt   = 4'd0;
                            pos_nxt    = 4'd0;
                        end
                    end
                end

                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HUNT;
            pos      <= 4'd0;
            hit_cnt  <= 4'd0;
            miss_cnt <= 4'd0;
            dout_r   <= 8'd0;
            dv_r     <= 1'b0;
            amt_r    <= 3'd0;
            locked_r <= 1'b0;
        end else begin
            state    <= state_nxt;
            pos      <= pos_nxt;
            hit_cnt  <= hit_nxt;
            miss_cnt <= miss_nxt;
            dout_r   <= dout_nxt;
            dv_r     <= dv_nxt;
            amt_r    <= amt_nxt;
            locked_r <= locked_nxt;
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dv_r;
    assign bus.amt        = amt_r;
    assign bus.locked     = locked_r;

endmodule

// File: tb/tb_rotate_aligner.sv
module tb_rotate_aligner;

    logic clk;
    logic reset;

    rotate_aligner_if bus ();

    rotate_aligner #(
        .SYNC      (8'hB0),
        .FRAME_LEN (4),
        .LOCK_CNT  (3),
        .LOSS_CNT  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
        logic [15:0] d;
        d = {x, x} << k;
        return d[15:8];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every dout_valid strobe must match the next queued expectation.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (bus.dout_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_dout_valid: got dout %h expected no output at %0t",
                             bus.dout, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.dout !== e) begin
                        n_fail++;
                        $display("FAIL dout: got %h expected %h at %0t", bus.dout, e, $time);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [7:0] w, input bit emit, input logic [7:0] expv);
        bus.din       = w;
        bus.din_valid = 1'b1;
        if (emit) exp_q.push_back(expv);
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] sync, input logic [7:0] data,
                              input bit emit, input logic [7:0] expv);
        send_word(sync, 1'b0, 8'h00);
        for (int i = 1; i < 4; i++) send_word(data, emit, expv);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.din       = 8'h00;
        bus.din_valid = 1'b0;
        idle(2);
        reset = 1'b0;
        check("reset_dout",   bus.dout, 8'h00);
        check("reset_dv",     8'(bus.dout_valid), 8'h00);
        check("reset_amt",    8'(bus.amt), 8'h00);
        check("reset_locked", 8'(bus.locked), 8'h00);

        // Clean lock at rotation 3
        send_frame(8'h85, 8'h90, 1'b0, 8'h00);
        check("lock1_f1_locked", 8'(bus.locked), 8'h00);
        send_frame(8'h85, 8'h90, 1'b0, 8'h00);
        check("lock1_f2_locked", 8'(bus.locked), 8'h00);
        send_word(8'h85, 1'b0, 8'h00);
        check("lock1_locked", 8'(bus.locked), 8'h01);
        check("lock1_amt",    8'(bus.amt), 8'h03);
        for (int i = 1; i < 4; i++) send_word(8'h90, 1'b1, 8'h12);

        // Miss counter cleared by a single hit, then loss of lock
        send_frame(8'h00, 8'h90, 1'b1, 8'h12);
        send_frame(8'h00, 8'h90, 1'b1, 8'h12);
        send_frame(8'h85, 8'h90, 1'b1, 8'h12);
        send_frame(8'h00, 8'h90, 1'b1, 8'h12);
        send_frame(8'h00, 8'h90, 1'b1, 8'h12);
        send_frame(8'h00, 8'h90, 1'b1, 8'h12);
        check("miss3_locked", 8'(bus.locked), 8'h01);
        check("miss3_amt",    8'(bus.amt), 8'h03);
        send_word(8'h00, 1'b0, 8'h00);
        check("loss_locked", 8'(bus.locked), 8'h00);
        for (int i = 1; i < 4; i++) send_word(8'h90, 1'b0, 8'h00);
        idle(2);

        // Confirm failure then clean relock
        do_reset();
        send_frame(8'h85, 8'h90, 1'b0, 8'h00);
        send_frame(8'h00, 8'h90, 1'b0, 8'h00);
        check("cfail_locked", 8'(bus.locked), 8'h00);
        send_frame(8'h85, 8'h90, 1'b0, 8'h00);
        send_frame(8'h85, 8'h90, 1'b0, 8'h00);
        check("cfail_f2_locked", 8'(bus.locked), 8'h00);
        send_word(8'h85, 1'b0, 8'h00);
        check("cfail_relock", 8'(bus.locked), 8'h01);
        check("cfail_amt",    8'(bus.amt), 8'h03);
        for (int i = 1; i < 4; i++) send_word(8'h90, 1'b1, 8'h12);

        // Random valid gaps while locked, distinct payload values
        for (int f = 0; f < 4; f++) begin
            send_word(8'h85, 1'b0, 8'h00);
            idle($urandom_range(0, 3));
            for (int j = 1; j < 4; j++) begin
                logic [7:0] v;
                v = 8'(f * 16 + j + 8'h30);
                send_word(rotl(v, 3), 1'b1, v);
                idle($urandom_range(0, 3));
            end
        end
        check("gap_locked", 8'(bus.locked), 8'h01);

        // Reset mid-frame while locked, with din_valid high on the same edge
        send_word(8'h85, 1'b0, 8'h00);
        send_word(8'h90, 1'b1, 8'h12);
        bus.din       = 8'h90;
        bus.din_valid = 1'b1;
        reset         = 1'b1;
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.din_valid = 1'b0;
        check("mreset_dout",   bus.dout, 8'h00);
        check("mreset_dv",     8'(bus.dout_valid), 8'h00);
        check("mreset_amt",    8'(bus.amt), 8'h00);
        check("mreset_locked", 8'(bus.locked), 8'h00);
        send_frame(8'h85, 8'h90, 1'b0, 8'h00);
        send_frame(8'h85, 8'h90, 1'b0, 8'h00);
        check("mreset_hunt_locked", 8'(bus.locked), 8'h00);
        send_word(8'h85, 1'b0, 8'h00);
        check("mreset_relock", 8'(bus.locked), 8'h01);
        for (int i = 1; i < 4; i++) send_word(8'h90, 1'b1, 8'h12);

        // All eight rotations
        for (int k = 0; k < 8; k++) begin
            do_reset();
            send_frame(rotl(8'hB0, k), rotl(8'hA5, k), 1'b0, 8'h00);
            send_frame(rotl(8'hB0, k), rotl(8'hA5, k), 1'b0, 8'h00);
            send_word(rotl(8'hB0, k), 1'b0, 8'h00);
            check("rot_locked", 8'(bus.locked), 8'h01);
            check("rot_amt",    8'(bus.amt), 8'(k));
            for (int i = 1; i < 4; i++) send_word(rotl(8'hA5, k), 1'b1, 8'hA5);
        end

        idle(3);
        check("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rotate_aligner.md
# rotate_aligner

Receive-side companion to the 8-bit rotating barrel shifter: recovers the unknown left-rotation amount applied to a byte stream and de-rotates every data byte. Incoming words are framed. Word 0 of each `FRAME_LEN`-word frame is the sync pattern `SYNC`, rotated like the payload. The block hunts for the rotation that maps an input word onto `SYNC`, confirms it over several frames, then locks and streams de-rotated payload. It sits directly downstream of the rotating link, in front of payload consumers.

## Interface
- `SYNC`, 8'hB0, sync pattern; its 8 rotations must all be distinct.
- `FRAME_LEN`, 4, words per frame including the sync word; legal range 2..16.
- `LOCK_CNT`, 3, consecutive sync hits (including the first) needed to declare lock; legal range 1..15.
- `LOSS_CNT`, 4, consecutive sync misses while locked that drop lock; legal range 1..15.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `din` in 8: rotated input word.
- `din_valid` in 1: `din` is valid this cycle. State only advances on valid cycles.
- `dout` out 8: de-rotated payload word, `rotr(din, amt)`.
- `dout_valid` out 1: one-cycle strobe; `dout` holds a payload word.
- `amt` out 3: current rotation estimate, valid when `locked`=1.
- `locked` out 1: alignment established.

## Operation
Notation: `rotr(x,k)` means rotate right by k (undoes a left rotate by k). `pos` is a frame-position counter in 0..FRAME_LEN-1; slot 0 is the sync slot.

The FSM has three states: HUNT, CONFIRM and LOCKED.

- **HUNT:**
  - On each valid word, evaluate all 8 candidates k with `rotr(din,k)==SYNC`.
  - On a match: `amt`<=k, `hit_cnt`<=1, `pos`<=1.
    - If LOCK_CNT==1, go to LOCKED (`locked`<=1, `miss_cnt`<=0).
    - Otherwise go to CONFIRM.
  - With no match, stay in HUNT.
  - `dout_valid` is never asserted in HUNT.
- **CONFIRM:**
  - Each valid word advances `pos` modulo FRAME_LEN.
  - At `pos`==0, check `rotr(din,amt)==SYNC`:
    - Hit: `hit_cnt`++. When `hit_cnt` reaches LOCK_CNT, go to LOCKED (`locked`<=1, `miss_cnt`<=0).
    - Miss: go to HUNT, `hit_cnt`<=0. The missed word is not re-evaluated as a HUNT candidate.
  - Payload words (`pos`!=0) are not output.
- **LOCKED:**
  - Payload words (`pos`!=0): `dout`<=`rotr(din,amt)`, `dout_valid`<=1.
  - Sync slot (`pos`==0): never output.
    - Hit: `miss_cnt`<=0.
    - Miss: `miss_cnt`++. When it reaches LOSS_CNT, go to HUNT (`locked`<=0, `miss_cnt`<=0).
  - `amt` is never changed while LOCKED.
- `dout_valid` is 0 on every cycle with `din_valid`=0.
- Width rules: `pos` is 4 bits, and `hit_cnt` and `miss_cnt` are 4 bits. Counters saturate only via the state transitions above; no wrap past the limit.

## Timing
- All outputs are registered. A payload word accepted on edge N appears on `dout`/`dout_valid` in the cycle following edge N: latency 1.
- `locked` rises in the cycle after the edge that accepts the LOCK_CNT-th sync hit. The first payload word of that frame is output.
- `locked` falls in the cycle after the edge that accepts the LOSS_CNT-th consecutive miss.
- Reset values: `dout`=0, `dout_valid`=0, `amt`=0, `locked`=0, state HUNT, `pos`=0, `hit_cnt`=0, `miss_cnt`=0.
- Reset asserted mid-frame or mid-lock overrides `din_valid` on the same edge.
- Gaps in `din_valid` freeze all state; `dout` holds its last value.
- Back-to-back valid words are supported at full rate: one word per clock, no backpressure.

## Test plan
- **Clean lock, rotation 3.** Frames of {8'h85, 8'h90, 8'h90, 8'h90}, where 8'h85 is `rotl(B0,3)` and 8'h90 is `rotl(12,3)`, repeated 3 times.
  - `amt`=3.
  - `locked` rises after the third 8'h85.
  - Frame 3 payload emits `dout`=8'h12 ×3, each `dout_valid` 1 cycle after its input.
  - No `dout_valid` during frames 1–2.
- **Confirm failure.** One frame with sync 8'h85, next sync slot 8'h00.
  - Returns to HUNT.
  - `locked` stays 0, no `dout_valid`.
  - A following clean sequence of 3 frames locks normally.
- **Loss of lock.** From lock at `amt`=3, send 4 frames with sync slot 8'h00.
  - Payload continues de-rotated during misses 1–3.
  - `locked` falls after the 4th miss.
  - No `dout_valid` afterwards.
  - A single hit after 2 misses clears `miss_cnt`: 3 further misses do not drop lock.
- **All rotations.** For k=0..7, stream sync `rotl(B0,k)` with data `rotl(8'hA5,k)`.
  - Each case locks with `amt`=k and `dout`=8'hA5.
- **Valid gaps and reset.** While locked, insert random 0–3-cycle `din_valid` gaps.
  - Output order and values are unchanged, with no spurious `dout_valid`.
  - Assert `reset` for 1 cycle mid-frame: next cycle all outputs are 0 and the FSM is in HUNT.
